// File: rtl/wb_port_arbiter_if.sv
// Result-stream, control-resolution and writeback bundle for wb_port_arbiter.
interface wb_port_arbiter_if #(
  parameter int NUM_REQ         = 4,
  parameter int NUM_PORTS       = 2,
  parameter int DATA_W          = 32,
  parameter int TAG_W           = 7,
  parameter int AL_W            = 7,
  parameter int CHECKPOINTS     = 8,
  parameter int CHECKPOINTS_LOG = 3
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]             req_valid_i;
  logic [NUM_REQ-1:0]             req_ready_o;
  logic [NUM_REQ*TAG_W-1:0]       req_tag_i;
  logic [NUM_REQ*DATA_W-1:0]      req_data_i;
  logic [NUM_REQ*AL_W-1:0]        req_al_i;
  logic [NUM_REQ*CHECKPOINTS-1:0] req_mask_i;
  logic                           ctrl_verified_i;
  logic                           ctrl_mispredict_i;
  logic [CHECKPOINTS_LOG-1:0]     ctrl_smt_id_i;
  logic [NUM_PORTS-1:0]           wb_valid_o;
  logic [NUM_PORTS*TAG_W-1:0]     wb_tag_o;
  logic [NUM_PORTS*DATA_W-1:0]    wb_data_o;
  logic [NUM_PORTS*AL_W-1:0]      wb_al_o;
  logic [NUM_PORTS*SRC_W-1:0]     wb_src_o;
  logic                           busy_o;

  modport master (
    output req_valid_i, req_tag_i, req_data_i, req_al_i, req_mask_i,
    output ctrl_verified_i, ctrl_mispredict_i, ctrl_smt_id_i,
    input  req_ready_o, wb_valid_o, wb_tag_o, wb_data_o, wb_al_o, wb_src_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_tag_i, req_data_i, req_al_i, req_mask_i,
    input  ctrl_verified_i, ctrl_mispredict_i, ctrl_smt_id_i,
    output req_ready_o, wb_valid_o, wb_tag_o, wb_data_o, wb_al_o, wb_src_o, busy_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: per-FU result FIFOs with branch-mask squash/clear,
// round-robin grant of up to NUM_PORTS heads per cycle onto registered ports.

// Per-requester result FIFO. The grantable head is the first entry that
// survives this cycle's squash; survivors compact toward the head.
module wb_req_buf #(
  parameter int BUF_DEPTH       = 2,
  parameter int TAG_W           = 7,
  parameter int DATA_W          = 32,
  parameter int AL_W            = 7,
  parameter int CHECKPOINTS     = 8,
  parameter int CHECKPOINTS_LOG = 3
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      inValid,
  input  logic [TAG_W+DATA_W+AL_W+CHECKPOINTS-1:0]  inEntry,
  input  logic                                      squash,
  input  logic                                      clear,
  input  logic [CHECKPOINTS_LOG-1:0]                smtId,
  input  logic                                      pop,
  output logic                                      ready,
  output logic                                      nonEmpty,
  output logic                                      headValid,
  output logic [TAG_W+DATA_W+AL_W+CHECKPOINTS-1:0]  headEntry
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0]       tag;
    logic [DATA_W-1:0]      data;
    logic [AL_W-1:0]        al;
    logic [CHECKPOINTS-1:0] mask;
  } entry_t;

  entry_t               mem     [BUF_DEPTH];
  entry_t               ordered [BUF_DEPTH];
  entry_t               remain  [BUF_DEPTH];
  entry_t               inE, inStore, headE;
  logic [PTR_W-1:0]     head, tail;
  logic [CNT_W-1:0]     count, nRemain;
  logic [BUF_DEPTH-1:0] keep;
  logic                 popNow, inKill, doPush, skip;

  assign inE       = inEntry;
  assign ready     = count < CNT_W'(BUF_DEPTH);
  assign nonEmpty  = count != '0;
  assign headEntry = headE;
  assign popNow    = pop && headValid;
  assign inKill    = squash && inE.mask[smtId];
  assign doPush    = inValid && ready && !inKill;

  // logical view from the head, marking entries that survive a squash
  always_comb begin
    for (int i = 0; i < BUF_DEPTH; i++) begin
      ordered[i] = mem[head + PTR_W'(i)];
      keep[i]    = (CNT_W'(i) < count) && !(squash && ordered[i].mask[smtId]);
    end
  end

  // first survivor is what the scheduler may pop
  always_comb begin
    headValid = 1'b0;
    headE     = '0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (keep[i] && !headValid) begin
        headValid = 1'b1;
        headE     = ordered[i];
      end
    end
  end

  // survivors minus the popped head, packed in order from position 0
  always_comb begin
    remain  = '{default: '0};
    nRemain = '0;
    skip    = popNow;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (keep[i]) begin
        if (skip) begin
          skip = 1'b0;
        end else begin
          remain[nRemain[PTR_W-1:0]] = ordered[i];
          nRemain = nRemain + CNT_W'(1);
        end
      end
    end
  end

  // incoming entry has the resolved bit cleared before it is stored
  always_comb begin
    inStore = inE;
    if (clear) inStore.mask[smtId] = 1'b0;
  end

  // squash cycles rewrite survivors from the head; other cycles move pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (squash) begin
        for (int j = 0; j < BUF_DEPTH; j++)
          if (CNT_W'(j) < nRemain) mem[head + PTR_W'(j)] <= remain[j];
        if (doPush) mem[head + nRemain[PTR_W-1:0]] <= inStore;
        tail <= head + nRemain[PTR_W-1:0] + PTR_W'(doPush);
      end else begin
        if (clear)
          for (int j = 0; j < BUF_DEPTH; j++) mem[j].mask[smtId] <= 1'b0;
        if (doPush) mem[tail] <= inStore;
        if (popNow) head <= head + PTR_W'(1);
        tail <= tail + PTR_W'(doPush);
      end
      count <= nRemain + CNT_W'(doPush);
    end
  end

  // valid while full is an upstream protocol error; the entry is dropped
  pushWhileFull: assert property (@(posedge clk) disable iff (reset) !(inValid && !ready));
endmodule

module wb_port_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int NUM_PORTS       = 2,
  parameter int BUF_DEPTH       = 2,
  parameter int DATA_W          = 32,
  parameter int TAG_W           = 7,
  parameter int AL_W            = 7,
  parameter int CHECKPOINTS     = 8,
  parameter int CHECKPOINTS_LOG = 3
) (
  input logic               clk,
  input logic               reset,
  wb_port_arbiter_if.slave  bus
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int ENT_W = TAG_W + DATA_W + AL_W + CHECKPOINTS;

  typedef struct packed {
    logic [TAG_W-1:0]       tag;
    logic [DATA_W-1:0]      data;
    logic [AL_W-1:0]        al;
    logic [CHECKPOINTS-1:0] mask;
  } entry_t;

  logic                              squash, clear, anyGrant;
  logic [NUM_REQ-1:0]                readyVec, nonEmpty, headValid, grant;
  logic [NUM_REQ-1:0][ENT_W-1:0]     inVec, headVec;
  logic [NUM_PORTS-1:0]              portVld;
  logic [NUM_PORTS-1:0][SRC_W-1:0]   portSel;
  logic [SRC_W-1:0]                  rrPtr, lastIdx;
  int                                scanIdx, portCnt;
  entry_t                            portEnt [NUM_PORTS];

  logic [NUM_PORTS-1:0]              wbValid;
  logic [NUM_PORTS-1:0][TAG_W-1:0]   wbTag;
  logic [NUM_PORTS-1:0][DATA_W-1:0]  wbData;
  logic [NUM_PORTS-1:0][AL_W-1:0]    wbAl;
  logic [NUM_PORTS-1:0][SRC_W-1:0]   wbSrc;

  assign squash          = bus.ctrl_verified_i &  bus.ctrl_mispredict_i;
  assign clear           = bus.ctrl_verified_i & ~bus.ctrl_mispredict_i;
  assign bus.req_ready_o = readyVec;
  assign bus.busy_o      = |nonEmpty;
  assign bus.wb_valid_o  = wbValid;
  assign bus.wb_tag_o    = wbTag;
  assign bus.wb_data_o   = wbData;
  assign bus.wb_al_o     = wbAl;
  assign bus.wb_src_o    = wbSrc;

  // unpack the flat request buses into one entry per requester
  always_comb begin
    for (int r = 0; r < NUM_REQ; r++)
      inVec[r] = {bus.req_tag_i[r*TAG_W +: TAG_W], bus.req_data_i[r*DATA_W +: DATA_W],
                  bus.req_al_i[r*AL_W +: AL_W], bus.req_mask_i[r*CHECKPOINTS +: CHECKPOINTS]};
  end

  for (genvar r = 0; r < NUM_REQ; r++) begin : gReq
    wb_req_buf #(
      .BUF_DEPTH(BUF_DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .AL_W(AL_W),
      .CHECKPOINTS(CHECKPOINTS), .CHECKPOINTS_LOG(CHECKPOINTS_LOG)
    ) uBuf (
      .clk       (clk),
      .reset     (reset),
      .inValid   (bus.req_valid_i[r]),
      .inEntry   (inVec[r]),
      .squash    (squash),
      .clear     (clear),
      .smtId     (bus.ctrl_smt_id_i),
      .pop       (grant[r]),
      .ready     (readyVec[r]),
      .nonEmpty  (nonEmpty[r]),
      .headValid (headValid[r]),
      .headEntry (headVec[r])
    );
  end

  // round-robin scan from rrPtr: k-th grantable requester takes port k
  always_comb begin
    grant    = '0;
    portVld  = '0;
    portSel  = '0;
    lastIdx  = rrPtr;
    anyGrant = 1'b0;
    scanIdx  = 0;
    portCnt  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scanIdx = int'(rrPtr) + i;
      if (scanIdx >= NUM_REQ) scanIdx = scanIdx - NUM_REQ;
      if (headValid[scanIdx] && portCnt < NUM_PORTS) begin
        grant[scanIdx]   = 1'b1;
        portVld[portCnt] = 1'b1;
        portSel[portCnt] = SRC_W'(scanIdx);
        lastIdx          = SRC_W'(scanIdx);
        anyGrant         = 1'b1;
        portCnt          = portCnt + 1;
      end
    end
  end

  // route each granted head to its port
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) portEnt[p] = headVec[portSel[p]];
  end

  // port registers hold their fields when idle; rrPtr moves past the last winner
  always_ff @(posedge clk) begin
    if (reset) begin
      wbValid <= '0;
      wbTag   <= '0;
      wbData  <= '0;
      wbAl    <= '0;
      wbSrc   <= '0;
      rrPtr   <= '0;
    end else begin
      wbValid <= portVld;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (portVld[p]) begin
          wbTag[p]  <= portEnt[p].tag;
          wbData[p] <= portEnt[p].data;
          wbAl[p]   <= portEnt[p].al;
          wbSrc[p]  <= portSel[p];
        end
      end
      if (anyGrant) rrPtr <= (lastIdx == SRC_W'(NUM_REQ - 1)) ? '0 : lastIdx + SRC_W'(1);
    end
  end
endmodule
